// File: rtl/score_argmax.sv
// ----------------------------------------------------------------------------
// score_argmax
//
// Scans one frame of NUM_CLASSES signed scores that arrive serially in class
// order and reports the index and value of the largest one. Ties keep the
// lowest index. A start pulse opens a frame; a start inside a frame abandons
// it and begins again. A score that arrives while no frame is open is
// dropped and flagged on a sticky error bit.
//
// Optional feature (macro SCORE_ARGMAX_BUF_EN):
//   Every accepted score is also stored in a NUM_CLASSES-entry register
//   buffer, readable through i_rd_addr / o_rd_data with one cycle of latency.
//   Without the macro there is no storage and o_rd_data stays 0.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_start        one-cycle pulse, begins a new frame
//   i_score_valid  i_score_in is valid this cycle
//   i_score_in     signed score, class order 0..NUM_CLASSES-1
//   o_busy         high while a frame is being scanned
//   o_result_valid high from frame completion until the next start or reset
//   o_class_idx    index of the maximum score
//   o_max_score    value of the maximum score
//   o_err_overrun  sticky, a score arrived outside a frame
//   i_rd_addr      score buffer read address
//   o_rd_data      score buffer read data (registered)
// ----------------------------------------------------------------------------
module score_argmax #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned IDX_W       = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_score_valid,
    input  logic [DATA_W-1:0] i_score_in,
    output logic              o_busy,
    output logic              o_result_valid,
    output logic [IDX_W-1:0]  o_class_idx,
    output logic [DATA_W-1:0] o_max_score,
    output logic              o_err_overrun,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

    state_e              r_state;
    state_e              w_state_d;
    logic [IDX_W-1:0]    r_count;
    logic                r_busy;
    logic                r_result_valid;
    logic [IDX_W-1:0]    r_class_idx;
    logic [DATA_W-1:0]   r_max_score;
    logic                r_err_overrun;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_accept;
    logic [IDX_W-1:0]    w_idx;
    logic                w_last;
    logic                w_overrun;
    logic                w_take;

    // A score in the same cycle as start belongs to the new frame as class 0.
    assign w_accept  = i_score_valid && (i_start || (r_state == StScan));
    assign w_idx     = i_start ? '0 : r_count;
    assign w_last    = w_accept && (w_idx == LastIdx);
    assign w_overrun = i_score_valid && !i_start && (r_state != StScan);

    // The first score of a frame always loads, so no sentinel is needed and
    // the most negative score is handled like any other.
    assign w_take = (w_idx == '0) || ($signed(i_score_in) > $signed(r_max_score));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_d = StScan;
            StScan:  w_state_d = StScan;
            StDone:  if (i_start) w_state_d = StScan;
            default: w_state_d = StIdle;
        endcase
        if (w_last) begin
            w_state_d = StDone;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_class_idx    <= '0;
            r_max_score    <= '0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_busy         <= (w_state_d == StScan);
            r_result_valid <= (w_state_d == StDone);

            if (w_accept) begin
                // Return to 0 after the last class so count stays in range.
                r_count <= w_last ? '0 : (w_idx + IDX_W'(1));
                if (w_take) begin
                    r_max_score <= i_score_in;
                    r_class_idx <= w_idx;
                end
            end else if (i_start) begin
                r_count <= '0;
            end

            if (w_overrun) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

`ifdef SCORE_ARGMAX_BUF_EN
    logic [DATA_W-1:0] r_buf [NUM_CLASSES];
    logic [DATA_W-1:0] w_rd_sel;

    // Out-of-range addresses fall through to 0.
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            if (i_rd_addr == IDX_W'(i)) begin
                w_rd_sel = r_buf[i];
            end
        end
    end

    // Read samples the pre-write contents, so a same-address write in this
    // cycle is not visible until the following read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                r_buf[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                    if (w_idx == IDX_W'(i)) begin
                        r_buf[i] <= i_score_in;
                    end
                end
            end
            r_rd_data <= w_rd_sel;
        end
    end
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^i_rd_addr;

    always_ff @(posedge i_clk) begin
        r_rd_data <= '0;
    end
`endif

    assign o_busy         = r_busy;
    assign o_result_valid = r_result_valid;
    assign o_class_idx    = r_class_idx;
    assign o_max_score    = r_max_score;
    assign o_err_overrun  = r_err_overrun;
    assign o_rd_data      = r_rd_data;

endmodule

// File: tb/tb_score_argmax.sv
module tb_score_argmax;

    logic        clk;
    logic        reset;
    logic        start;
    logic        score_valid;
    logic [15:0] score_in;
    logic        busy;
    logic        result_valid;
    logic [3:0]  class_idx;
    logic [15:0] max_score;
    logic        err_overrun;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;

    int n_tests;
    int n_fail;

    score_argmax #(
        .NUM_CLASSES(10),
        .DATA_W     (16),
        .IDX_W      (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_score_valid (score_valid),
        .i_score_in    (score_in),
        .o_busy        (busy),
        .o_result_valid(result_valid),
        .o_class_idx   (class_idx),
        .o_max_score   (max_score),
        .o_err_overrun (err_overrun),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the edge, inputs change at the same time.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] s, input logic st);
        start       = st;
        score_valid = 1'b1;
        score_in    = s;
        tick();
        start       = 1'b0;
        score_valid = 1'b0;
        score_in    = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rv"},   32'(result_valid), 32'd0);
        check({tag, "_idx"},  32'(class_idx), 32'd0);
        check({tag, "_max"},  32'(max_score), 32'd0);
        check({tag, "_err"},  32'(err_overrun), 32'd0);
    endtask

    logic [15:0] f1 [10];
    logic [15:0] f2 [10];

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        start       = 1'b0;
        score_valid = 1'b0;
        score_in    = '0;
        rd_addr     = '0;
        f1 = '{16'h0100, 16'h0200, 16'hFF00, 16'h0800, 16'h0050,
               16'h0000, 16'h0700, 16'h0001, 16'h0002, 16'h0003};
        f2 = '{16'h8000, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000,
               16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000};
        #1;
        idle(2);
        reset = 1'b0;
        tick();
        check_zero_state("reset");
        check("reset_rd", 32'(rd_data), 32'd0);

        // Frame 1: basic argmax, back-to-back scores.
        pulse_start();
        check("f1_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            send(f1[i], 1'b0);
            if (i == 8) check("f1_rv_before_last", 32'(result_valid), 32'd0);
        end
        check("f1_rv",   32'(result_valid), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);
        check("f1_idx",  32'(class_idx), 32'd3);
        check("f1_max",  32'(max_score), 32'h0800);

        rd_addr = 4'd3;
        tick();
`ifdef SCORE_ARGMAX_BUF_EN
        check("buf_rd3", 32'(rd_data), 32'h0800);
`else
        check("buf_rd3", 32'(rd_data), 32'h0000);
`endif
        rd_addr = 4'd12;
        tick();
        check("buf_rd12", 32'(rd_data), 32'h0000);
        rd_addr = 4'd2;
        tick();
`ifdef SCORE_ARGMAX_BUF_EN
        check("buf_rd2", 32'(rd_data), 32'hFF00);
`else
        check("buf_rd2", 32'(rd_data), 32'h0000);
`endif
        rd_addr = 4'd0;
        check("f1_hold_rv", 32'(result_valid), 32'd1);

        // Frame 2: all negative, tie between idx 2 and 6.
        pulse_start();
        check("f2_rv_clear", 32'(result_valid), 32'd0);
        for (int i = 0; i < 10; i++) send(f2[i], 1'b0);
        check("f2_rv",  32'(result_valid), 32'd1);
        check("f2_idx", 32'(class_idx), 32'd2);
        check("f2_max", 32'(max_score), 32'hFFFF);

        // Frame 3: score with start, then gapped zeros.
        send(16'h7FFF, 1'b1);
        check("f3_busy0", 32'(busy), 32'd1);
        for (int i = 0; i < 9; i++) begin
            idle(3);
            check("f3_busy_gap", 32'(busy), 32'd1);
            send(16'h0000, 1'b0);
        end
        check("f3_rv",  32'(result_valid), 32'd1);
        check("f3_idx", 32'(class_idx), 32'd0);
        check("f3_max", 32'(max_score), 32'h7FFF);

        // Frame 4: abort after 4 large scores, restart, max at idx 9.
        pulse_start();
        for (int i = 0; i < 4; i++) send(16'h7000, 1'b0);
        pulse_start();
        check("f4_abort_busy", 32'(busy), 32'd1);
        check("f4_abort_rv",   32'(result_valid), 32'd0);
        for (int i = 0; i < 9; i++) send(16'h0100, 1'b0);
        check("f4_rv_before_last", 32'(result_valid), 32'd0);
        send(16'h0400, 1'b0);
        check("f4_rv",  32'(result_valid), 32'd1);
        check("f4_idx", 32'(class_idx), 32'd9);
        check("f4_max", 32'(max_score), 32'h0400);
        check("f4_err0", 32'(err_overrun), 32'd0);

        // Overrun in DONE: flagged, results unchanged.
        send(16'h7FFF, 1'b0);
        check("ovr_err",  32'(err_overrun), 32'd1);
        check("ovr_idx",  32'(class_idx), 32'd9);
        check("ovr_max",  32'(max_score), 32'h0400);
        check("ovr_rv",   32'(result_valid), 32'd1);
        idle(2);
        check("ovr_sticky", 32'(err_overrun), 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero_state("rst2");

        // Reset mid-frame, then a clean frame.
        pulse_start();
        for (int i = 0; i < 5; i++) send(f1[i], 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero_state("rst_mid");
        pulse_start();
        for (int i = 0; i < 10; i++) send(f1[i], 1'b0);
        check("f5_rv",  32'(result_valid), 32'd1);
        check("f5_idx", 32'(class_idx), 32'd3);
        check("f5_max", 32'(max_score), 32'h0800);
        check("f5_err", 32'(err_overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
